cvp14_mem_responder: RTL and testbench



---
 rtl/cvp14_mem_pkg.sv | 18 +
 rtl/cvp14_mem_responder_if.sv | 15 +
 rtl/cvp14_wbuf.sv | 89 ++++++++
 rtl/cvp14_mem_responder.sv | 103 ++++++++++
 tb/tb_cvp14_mem_responder.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/cvp14_mem_pkg.sv
// Shared types and constants for the CVP14 memory responder.
package cvp14_mem_pkg;

  localparam int DATA_W     = 16;
  localparam int BUS_ADDR_W = 16;

  typedef struct packed {
    logic [BUS_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } wb_state_t;

endpackage

// File: rtl/cvp14_mem_responder_if.sv
// Core-side memory bus of the CVP14: address, strobes, overflow and both data directions.
interface cvp14_mem_responder_if;
  import cvp14_mem_pkg::*;

  logic [BUS_ADDR_W-1:0] Addr;
  logic                  RD;
  logic                  WR;
  logic                  V;
  logic [DATA_W-1:0]     DataWr;
  logic [DATA_W-1:0]     DataRd;

  modport master (output Addr, output RD, output WR, output V, output DataWr, input DataRd);
  modport slave  (input Addr, input RD, input WR, input V, input DataWr, output DataRd);

endinterface

// File: rtl/cvp14_wbuf.sv
// Posted-write FIFO with a parallel lookup returning the newest entry matching an address.
module cvp14_wbuf
  import cvp14_mem_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  wb_entry_t             entry,
  output wb_entry_t             head,
  input  logic [BUS_ADDR_W-1:0] lookup_addr,
  output logic                  hit,
  output logic [DATA_W-1:0]     hit_data,
  output logic [PTR_W:0]        fill,
  output wb_state_t             state
);

  localparam logic [PTR_W:0]   FILL_ONE = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   FILL_MAX = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  wb_entry_t        entries_r [DEPTH];
  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [PTR_W:0]   fill_r;
  logic [PTR_W:0]   fill_nxt_s;
  wb_state_t        state_r;
  logic [PTR_W-1:0] slot_s;
  logic             match_s;

  // occupancy after this cycle's push/pop
  always_comb begin
    if (push && !pop) begin
      fill_nxt_s = fill_r + FILL_ONE;
    end else if (pop && !push) begin
      fill_nxt_s = fill_r - FILL_ONE;
    end else begin
      fill_nxt_s = fill_r;
    end
  end

  // FIFO storage, pointers and controller state
  always_ff @(posedge clk) begin
    if (rst) begin
      head_r  <= '0;
      tail_r  <= '0;
      fill_r  <= '0;
      state_r <= EMPTY;
    end else begin
      if (push) begin
        entries_r[tail_r] <= entry;
        tail_r            <= tail_r + PTR_ONE;
      end
      if (pop) begin
        head_r <= head_r + PTR_ONE;
      end
      fill_r <= fill_nxt_s;
      case (state_r)
        EMPTY:   state_r <= push ? PARTIAL : EMPTY;
        PARTIAL: state_r <= (fill_nxt_s == FILL_MAX) ? FULL :
                            (fill_nxt_s == '0)       ? EMPTY : PARTIAL;
        FULL:    state_r <= (fill_nxt_s == FILL_MAX) ? FULL : PARTIAL;
        default: state_r <= EMPTY;
      endcase
    end
  end

  // walk oldest to newest so the last valid match wins
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    slot_s   = '0;
    match_s  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      slot_s   = head_r + PTR_W'(i);
      match_s  = ((PTR_W+1)'(i) < fill_r) && (entries_r[slot_s].addr == lookup_addr);
      hit_data = match_s ? entries_r[slot_s].data : hit_data;
      hit      = hit | match_s;
    end
  end

  assign head  = entries_r[head_r];
  assign fill  = fill_r;
  assign state = state_r;

endmodule

// File: rtl/cvp14_mem_responder.sv
// CVP14 memory-side responder: word array, posted write buffer with forwarding,
// registered read data and sticky overflow / protocol-error flags.
module cvp14_mem_responder
  import cvp14_mem_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int WB_DEPTH = 4
) (
  input  logic                      Clk1,
  input  logic                      Reset,
  cvp14_mem_responder_if.slave      bus,
  output logic [$clog2(WB_DEPTH):0] wb_fill,
  output logic                      ovf_sticky,
  output logic                      proto_err
);

  localparam int PTR_W = $clog2(WB_DEPTH);
  localparam logic [BUS_ADDR_W-1:0] ADDR_MASK = BUS_ADDR_W'((32'd1 << ADDR_W) - 32'd1);

  logic [DATA_W-1:0]     mem_r [2**ADDR_W];
  logic [DATA_W-1:0]     data_rd_r;
  logic                  ovf_r;
  logic                  perr_r;
  logic [BUS_ADDR_W-1:0] addr_s;
  logic [ADDR_W-1:0]     idx_s;
  wb_entry_t             entry_s;
  wb_entry_t             head_s;
  logic                  hit_s;
  logic [DATA_W-1:0]     hit_data_s;
  logic [PTR_W:0]        fill_s;
  wb_state_t             wb_state_s;
  logic                  pop_s;
  logic [DATA_W-1:0]     rd_data_s;
  logic                  unused_hi_s;

  // upper address bits alias away before anything is stored or compared
  assign addr_s       = bus.Addr & ADDR_MASK;
  assign idx_s        = addr_s[ADDR_W-1:0];
  assign entry_s.addr = addr_s;
  assign entry_s.data = bus.DataWr;
  assign unused_hi_s  = ^head_s.addr[BUS_ADDR_W-1:ADDR_W];

  // single array port: forced drain on write-when-full, otherwise drain only when idle
  assign pop_s = (bus.WR && (wb_state_s == FULL)) ||
                 (!bus.RD && !bus.WR && (wb_state_s != EMPTY));

  cvp14_wbuf #(.DEPTH(WB_DEPTH)) u_wbuf (
    .clk         (Clk1),
    .rst         (Reset),
    .push        (bus.WR),
    .pop         (pop_s),
    .entry       (entry_s),
    .head        (head_s),
    .lookup_addr (addr_s),
    .hit         (hit_s),
    .hit_data    (hit_data_s),
    .fill        (fill_s),
    .state       (wb_state_s)
  );

  // read source: simultaneous write data, then newest buffered write, then array
  always_comb begin
    if (bus.WR) begin
      rd_data_s = bus.DataWr;
    end else if (hit_s) begin
      rd_data_s = hit_data_s;
    end else begin
      rd_data_s = mem_r[idx_s];
    end
  end

  // array write port fed by the buffer head; contents survive Reset
  always_ff @(posedge Clk1) begin
    if (!Reset && pop_s) begin
      mem_r[head_s.addr[ADDR_W-1:0]] <= head_s.data;
    end
  end

  // read data register and sticky status
  always_ff @(posedge Clk1) begin
    if (Reset) begin
      data_rd_r <= '0;
      ovf_r     <= 1'b0;
      perr_r    <= 1'b0;
    end else begin
      if (bus.RD) begin
        data_rd_r <= rd_data_s;
      end
      if (bus.V) begin
        ovf_r <= 1'b1;
      end
      if (bus.RD && bus.WR) begin
        perr_r <= 1'b1;
      end
    end
  end

  assign bus.DataRd = data_rd_r;
  assign wb_fill    = fill_s;
  assign ovf_sticky = ovf_r;
  assign proto_err  = perr_r;

endmodule

// File: tb/tb_cvp14_mem_responder.sv
// Directed vector table for the documented scenarios, then random traffic checked
// against a queue-based reference model of the responder.
module tb_cvp14_mem_responder;
  import cvp14_mem_pkg::*;

  localparam int ADDR_W   = 10;
  localparam int WB_DEPTH = 4;

  logic       Clk1 = 1'b0;
  logic       Reset;
  logic [2:0] wb_fill;
  logic       ovf_sticky;
  logic       proto_err;

  cvp14_mem_responder_if bus();

  cvp14_mem_responder #(.ADDR_W(ADDR_W), .WB_DEPTH(WB_DEPTH)) dut (
    .Clk1       (Clk1),
    .Reset      (Reset),
    .bus        (bus),
    .wb_fill    (wb_fill),
    .ovf_sticky (ovf_sticky),
    .proto_err  (proto_err)
  );

  always #5 Clk1 = ~Clk1;

  typedef struct {
    logic        rst, rd, wr, v;
    logic [15:0] addr, wdata, exp_data;
    logic [2:0]  exp_fill;
    logic        exp_ovf, exp_perr;
  } vec_t;

  typedef struct {
    logic [9:0]  a;
    logic [15:0] d;
  } ent_t;

  vec_t vecs[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  // reference model state
  logic [15:0] m_mem   [1024];
  bit          m_known [1024];
  ent_t        m_q[$];
  logic [15:0] m_data;
  bit          m_data_known;
  bit          m_ovf, m_perr;

  function void add(bit rst, bit rd, bit wr, bit v, logic [15:0] addr, logic [15:0] wdata,
                    logic [15:0] expd, logic [2:0] f, bit o, bit p);
    vec_t x;
    x.rst = rst; x.rd = rd; x.wr = wr; x.v = v; x.addr = addr; x.wdata = wdata;
    x.exp_data = expd; x.exp_fill = f; x.exp_ovf = o; x.exp_perr = p;
    vecs.push_back(x);
  endfunction

  function void model_drain();
    ent_t e;
    e = m_q.pop_front();
    m_mem[e.a]   = e.d;
    m_known[e.a] = 1'b1;
  endfunction

  function void model_step(bit rst, bit rd, bit wr, bit v, logic [15:0] addr, logic [15:0] wdata);
    logic [9:0] idx;
    bit         found;
    ent_t       e;
    idx = addr[9:0];
    if (rst) begin
      m_q.delete();
      m_data = 16'h0000; m_data_known = 1'b1; m_ovf = 1'b0; m_perr = 1'b0;
    end else begin
      if (rd) begin
        if (wr) begin
          m_data = wdata; m_data_known = 1'b1;
        end else begin
          found = 1'b0;
          foreach (m_q[i]) begin
            if (m_q[i].a == idx) begin
              m_data = m_q[i].d; found = 1'b1;
            end
          end
          if (found) m_data_known = 1'b1;
          else begin
            m_data = m_mem[idx]; m_data_known = m_known[idx];
          end
        end
      end
      if (v) m_ovf = 1'b1;
      if (rd && wr) m_perr = 1'b1;
      if (wr) begin
        if (m_q.size() == WB_DEPTH) model_drain();
        e.a = idx; e.d = wdata;
        m_q.push_back(e);
      end else if (!rd && m_q.size() > 0) begin
        model_drain();
      end
    end
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic apply(input bit rst, input bit rd, input bit wr, input bit v,
                       input logic [15:0] addr, input logic [15:0] wdata);
    Reset = rst; bus.RD = rd; bus.WR = wr; bus.V = v; bus.Addr = addr; bus.DataWr = wdata;
    model_step(rst, rd, wr, v, addr, wdata);
    @(posedge Clk1);
    #1;
  endtask

  initial begin
    vec_t x;
    logic [15:0] ra, rw;
    bit rr, rwr, rv, rrst;
    int op;

    Reset = 1'b1; bus.RD = 1'b0; bus.WR = 1'b0; bus.V = 1'b0;
    bus.Addr = 16'h0000; bus.DataWr = 16'h0000;
    m_data = 16'h0000; m_data_known = 1'b0; m_ovf = 1'b0; m_perr = 1'b0;
    for (int i = 0; i < 1024; i++) m_known[i] = 1'b0;

    //  rst rd wr v  addr      wdata     data      fill  ovf perr
    add(1, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 3'd0, 0, 0);
    add(0, 0, 1, 0, 16'h0010, 16'hBEEF, 16'h0000, 3'd1, 0, 0);
    add(0, 1, 0, 0, 16'h0010, 16'h0000, 16'hBEEF, 3'd1, 0, 0);
    add(0, 0, 0, 0, 16'h0000, 16'h0000, 16'hBEEF, 3'd0, 0, 0);
    add(0, 0, 1, 0, 16'h0020, 16'h1111, 16'hBEEF, 3'd1, 0, 0);
    add(0, 0, 0, 0, 16'h0000, 16'h0000, 16'hBEEF, 3'd0, 0, 0);
    add(0, 0, 0, 0, 16'h0000, 16'h0000, 16'hBEEF, 3'd0, 0, 0);
    add(0, 0, 0, 0, 16'h0000, 16'h0000, 16'hBEEF, 3'd0, 0, 0);
    add(0, 1, 0, 0, 16'h0020, 16'h0000, 16'h1111, 3'd0, 0, 0);
    for (int i = 0; i < 16; i++)
      add(0, 0, 1, 0, 16'h0100 + 16'(i), 16'hA000 + 16'(i), 16'h1111, (i < 3) ? 3'(i + 1) : 3'd4, 0, 0);
    for (int i = 0; i < 16; i++)
      add(0, 1, 0, 0, 16'h0100 + 16'(i), 16'h0000, 16'hA000 + 16'(i), 3'd4, 0, 0);
    for (int i = 0; i < 4; i++)
      add(0, 0, 0, 0, 16'h0000, 16'h0000, 16'hA00F, 3'(3 - i), 0, 0);
    add(0, 0, 1, 0, 16'h0030, 16'h0001, 16'hA00F, 3'd1, 0, 0);
    add(0, 0, 1, 0, 16'h0030, 16'h0002, 16'hA00F, 3'd2, 0, 0);
    add(0, 1, 0, 0, 16'h0030, 16'h0000, 16'h0002, 3'd2, 0, 0);
    add(0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0002, 3'd1, 0, 0);
    add(0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0002, 3'd0, 0, 0);
    add(0, 1, 0, 0, 16'h0030, 16'h0000, 16'h0002, 3'd0, 0, 0);
    add(0, 0, 1, 0, 16'h0405, 16'h5A5A, 16'h0002, 3'd1, 0, 0);
    add(0, 1, 0, 0, 16'h0005, 16'h0000, 16'h5A5A, 3'd1, 0, 0);
    add(0, 0, 0, 0, 16'h0000, 16'h0000, 16'h5A5A, 3'd0, 0, 0);
    add(0, 1, 0, 0, 16'h0C05, 16'h0000, 16'h5A5A, 3'd0, 0, 0);
    add(0, 0, 0, 1, 16'h0000, 16'h0000, 16'h5A5A, 3'd0, 1, 0);
    add(0, 0, 0, 0, 16'h0000, 16'h0000, 16'h5A5A, 3'd0, 1, 0);
    add(0, 1, 1, 0, 16'h0040, 16'h7777, 16'h7777, 3'd1, 1, 1);
    add(0, 0, 0, 0, 16'h0000, 16'h0000, 16'h7777, 3'd0, 1, 1);
    // reset with three buffered writes: they must never reach the array
    add(0, 0, 1, 0, 16'h0100, 16'hDEAD, 16'h7777, 3'd1, 1, 1);
    add(0, 0, 1, 0, 16'h0101, 16'hDEAE, 16'h7777, 3'd2, 1, 1);
    add(0, 0, 1, 0, 16'h0102, 16'hDEAF, 16'h7777, 3'd3, 1, 1);
    add(1, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 3'd0, 0, 0);
    add(0, 1, 0, 0, 16'h0100, 16'h0000, 16'hA000, 3'd0, 0, 0);
    add(0, 1, 0, 0, 16'h0102, 16'h0000, 16'hA002, 3'd0, 0, 0);

    foreach (vecs[i]) begin
      x = vecs[i];
      apply(x.rst, x.rd, x.wr, x.v, x.addr, x.wdata);
      check($sformatf("vec%0d DataRd", i), bus.DataRd, x.exp_data);
      check($sformatf("vec%0d wb_fill", i), 16'(wb_fill), 16'(x.exp_fill));
      check($sformatf("vec%0d ovf_sticky", i), 16'(ovf_sticky), 16'(x.exp_ovf));
      check($sformatf("vec%0d proto_err", i), 16'(proto_err), 16'(x.exp_perr));
    end

    // random traffic over a small aliased window so forwarding and drains collide often
    for (int n = 0; n < 1500; n++) begin
      op   = int'($urandom_range(0, 9));
      rrst = ($urandom_range(0, 199) == 0);
      rr   = (op <= 2) || (op == 7);
      rwr  = (op >= 3) && (op <= 7);
      rv   = ($urandom_range(0, 49) == 0);
      ra   = 16'(($urandom_range(0, 63) << 10) | (32'h100 + $urandom_range(0, 7)));
      rw   = 16'($urandom);
      apply(rrst, rr, rwr, rv, ra, rw);
      if (m_data_known) check($sformatf("rnd%0d DataRd", n), bus.DataRd, m_data);
      check($sformatf("rnd%0d wb_fill", n), 16'(wb_fill), 16'(m_q.size()));
      check($sformatf("rnd%0d ovf_sticky", n), 16'(ovf_sticky), 16'(m_ovf));
      check($sformatf("rnd%0d proto_err", n), 16'(proto_err), 16'(m_perr));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
